pe_accum: RTL and testbench
===========================

// Module: pe_accum
// PURPOSE
//  Downstream stage of the PE multiply-reduce tree. Consumes one signed lane-sum y per beat and
//  accumulates cfg_len beats into one dot product, for vectors longer than C lanes.
//  Shifts and saturates the sum to W_OUT bits and presents it on a valid/ready output.
//  The controller drives the tree enable with s_ready and aligns s_valid to the tree latency.
// PARAMETERS
//  W_Y    20  input partial-sum width (W_X+W_K+$clog2(C) for C=16, W_X=W_K=8)
//  W_A    32  accumulator width; elaboration $error if W_A < W_Y+$clog2(N_MAX)
//  W_OUT  8   output width
//  N_MAX  256 max beats per dot product; W_N = $clog2(N_MAX+1)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  cfg_len    in   W_N    beats per dot product; 0 treated as 1; values > N_MAX clamp to N_MAX
//  cfg_shift  in   6      arithmetic right shift applied to final sum
//  s_valid    in   1      s_y valid this cycle
//  s_ready    out  1      block accepts s_y; controller gates tree enable with it
//  s_y        in   W_Y    signed partial sum from multiply-reduce tree
//  m_valid    out  1      result valid
//  m_ready    in   1      consumer accepts result
//  m_data     out  W_OUT  signed result
//  m_ovf      out  1      result was clipped by saturation (qualified by m_valid)
// BEHAVIOUR
//  Reset (synchronous, rst=1 at posedge): cnt=0, acc=0, state=IDLE, m_valid=0, m_data=0, m_ovf=0.
//   Any partial sum is discarded. s_ready is combinational and is 1 whenever m_valid=0.
//  Handshake: input beat when s_valid&&s_ready; output beat when m_valid&&m_ready.
//   s_ready = !m_valid || m_ready (combinational from m_ready; no other comb paths).
//   Once m_valid=1, m_data/m_ovf are held stable until the output beat.
//  FSM: IDLE (no partial sum) / ACC (partial sum in progress).
//   Beat in IDLE: latch len_q=max(cfg_len,1) (clamped) and shift_q=cfg_shift; acc=sext(s_y).
//    If len_q==1, finish at once and stay in IDLE; else cnt=1 and go to ACC.
//   Beat in ACC: acc+=sext(s_y), cnt++. When cnt reaches len_q, finish, cnt=0, go to IDLE.
//   cfg_* changes in ACC are ignored until the next IDLE beat.
//  Finish: sum = acc_next (sum including the current beat); r = sum >>> shift_q (floor).
//   Clip r to [-2^(W_OUT-1), 2^(W_OUT-1)-1]; m_ovf=1 iff clipped.
//   The result registers the same edge: m_valid=1 the cycle after the final beat (latency 1).
//  Simultaneous output beat and final input beat: the output register reloads and m_valid stays 1.
//   This gives a throughput of 1 result/cycle at cfg_len=1 with m_ready=1.
//  Non-final beats are accepted while m_valid=1 only if m_ready=1 (s_ready rule). No bypass.
//  acc cannot overflow given the W_A check; no internal wrap.
// CONFIGURATION
//  PE_ACCUM_RELU_EN defined: r<0 is forced to 0 before clipping; ReLU never sets m_ovf.
//  Not defined: signed results pass unchanged to clipping; no ReLU logic is synthesised.
// STRUCTURE
//  pe_pkg: W_X, W_K, C, W_Y; function w_y(c,wx,wk); typedef enum logic {IDLE,ACC} acc_state_t.
//  Sub-module pe_sat (combinational): shift, optional ReLU, clip, ovf flag; params W_A, W_OUT.
//  pe_accum holds the FSM, counter, accumulator and output register.
// TESTING (W_Y=20, W_A=32, W_OUT=8)
//  len=1, shift=0, y=5 -> next cycle m_valid=1, m_data=5, m_ovf=0.
//  len=4, shift=2, y=100,200,300,400 -> 1000>>>2=250 -> m_data=127, m_ovf=1.
//  len=2, shift=0, y=-3,-4 -> m_data=-7, m_ovf=0; with PE_ACCUM_RELU_EN -> m_data=0, m_ovf=0.
//  Result pending, m_ready=0 for 5 cycles: s_ready=0, m_data held; m_ready=1 -> s_ready=1 same cycle.
//  len=4, two beats of 9, rst 1 cycle, then four beats of 1 -> single result m_data=4.
//  len=1, m_ready=1, y=1..8 back-to-back -> 8 results on consecutive cycles.
//   Set cfg_len=3 mid-stream in a len=2 dot product: the current result uses len 2.

Source files
------------

// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared widths, width helper and accumulator state type for the PE pipeline
package pe_pkg;

  localparam int W_X = 8;
  localparam int W_K = 8;
  localparam int C   = 16;

  // Lane-sum width out of a C-lane multiply-reduce tree.
  function automatic int w_y(input int c, input int wx, input int wk);
    return wx + wk + $clog2(c);
  endfunction

  localparam int W_Y = w_y(C, W_X, W_K);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/pe_sat.sv
// rtl/pe_sat.sv - arithmetic shift, optional ReLU and signed saturation of a dot product
// Optional feature macro: PE_ACCUM_RELU_EN (negative results forced to zero before clipping).
module pe_sat #(
  parameter int W_A   = 32,
  parameter int W_OUT = 8
) (
  input  logic [W_A-1:0]   sum_i,
  input  logic [5:0]       shift_i,
  output logic [W_OUT-1:0] data_o,
  output logic             ovf_o
);

  localparam logic signed [W_A-1:0] SAT_MAX = {{(W_A-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
  localparam logic signed [W_A-1:0] SAT_MIN = {{(W_A-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};

  logic signed [W_A-1:0] shifted;
  logic signed [W_A-1:0] r;

  always_comb begin
    // Shifts at or beyond W_A collapse to the sign, which is the floor result.
    shifted = $signed(sum_i) >>> shift_i;
    r       = shifted;
`ifdef PE_ACCUM_RELU_EN
    if (shifted[W_A-1]) begin
      r = '0;
    end
`endif
    data_o = r[W_OUT-1:0];
    ovf_o  = 1'b0;
    if (r > SAT_MAX) begin
      data_o = SAT_MAX[W_OUT-1:0];
      ovf_o  = 1'b1;
    end else if (r < SAT_MIN) begin
      data_o = SAT_MIN[W_OUT-1:0];
      ovf_o  = 1'b1;
    end
  end

endmodule

// File: rtl/pe_accum.sv
// rtl/pe_accum.sv - accumulates cfg_len lane sums into one saturated dot product on a valid/ready output
// Optional feature macro: PE_ACCUM_RELU_EN (ReLU inside pe_sat).
module pe_accum
  import pe_pkg::*;
#(
  parameter int W_Y   = pe_pkg::W_Y,
  parameter int W_A   = 32,
  parameter int W_OUT = 8,
  parameter int N_MAX = 256,
  parameter int W_N   = $clog2(N_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_N-1:0]   cfg_len,
  input  logic [5:0]       cfg_shift,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W_Y-1:0]   s_y,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W_OUT-1:0] m_data,
  output logic             m_ovf
);

  if (W_A < W_Y + $clog2(N_MAX)) begin : g_w_a_check
    $error("pe_accum: W_A too narrow for W_Y and N_MAX");
  end

  acc_state_t       state_q, state_d;
  logic [W_N-1:0]   cnt_q, cnt_d;
  logic [W_N-1:0]   len_q, len_d;
  logic [5:0]       shift_q, shift_d;
  logic [W_A-1:0]   acc_q, acc_d;
  logic             m_valid_q, m_valid_d;
  logic [W_OUT-1:0] m_data_q, m_data_d;
  logic             m_ovf_q, m_ovf_d;

  logic [W_N-1:0]   len_clamped;
  logic [W_N-1:0]   eff_len;
  logic [5:0]       eff_shift;
  logic [W_N-1:0]   cnt_inc;
  logic [W_A-1:0]   y_ext;
  logic [W_A-1:0]   acc_sum;
  logic             beat;
  logic             finish;
  logic [W_OUT-1:0] sat_data;
  logic             sat_ovf;

  assign s_ready = !m_valid_q || m_ready;
  assign beat    = s_valid && s_ready;
  assign y_ext   = {{(W_A-W_Y){s_y[W_Y-1]}}, s_y};

  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0) begin
      len_clamped = W_N'(1);
    end else if (cfg_len > W_N'(N_MAX)) begin
      len_clamped = W_N'(N_MAX);
    end
  end

  // An IDLE beat starts a new product from the live cfg_* values; ACC uses the latched ones.
  always_comb begin
    if (state_q == IDLE) begin
      acc_sum   = y_ext;
      cnt_inc   = W_N'(1);
      eff_len   = len_clamped;
      eff_shift = cfg_shift;
    end else begin
      acc_sum   = acc_q + y_ext;
      cnt_inc   = cnt_q + W_N'(1);
      eff_len   = len_q;
      eff_shift = shift_q;
    end
    finish = beat && (cnt_inc == eff_len);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    if (beat) begin
      acc_d   = acc_sum;
      len_d   = eff_len;
      shift_d = eff_shift;
      if (finish) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d   = cnt_inc;
        state_d = ACC;
      end
    end
  end

  pe_sat #(
    .W_A   (W_A),
    .W_OUT (W_OUT)
  ) u_sat (
    .sum_i   (acc_sum),
    .shift_i (eff_shift),
    .data_o  (sat_data),
    .ovf_o   (sat_ovf)
  );

  // A finish can only coincide with a pending result when m_ready drains it this edge.
  always_comb begin
    m_valid_d = m_valid_q && !m_ready;
    m_data_d  = m_data_q;
    m_ovf_d   = m_ovf_q;
    if (finish) begin
      m_valid_d = 1'b1;
      m_data_d  = sat_data;
      m_ovf_d   = sat_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= W_N'(1);
      shift_q   <= '0;
      acc_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ovf_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ovf_q   <= m_ovf_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_ovf   = m_ovf_q;

endmodule

// File: tb/tb_pe_accum.sv
// tb/tb_pe_accum.sv - vector table, corner sequences and randomized scoreboard for pe_accum
module tb_pe_accum;

`ifdef PE_ACCUM_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  cfg_len;
  logic [5:0]  cfg_shift;
  logic        s_valid;
  logic        s_ready;
  logic [19:0] s_y;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_ovf;

  pe_accum #(.W_Y(20), .W_A(32), .W_OUT(8), .N_MAX(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_len   (cfg_len),
    .cfg_shift (cfg_shift),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_y       (s_y),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_ovf     (m_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]       len;
    logic [5:0]       shift;
    logic [2:0]       n;
    logic [3:0][19:0] y;
    logic [7:0]       exp_d;
    logic             exp_o;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic vec_t mk(input int len, input int sh, input int n,
                              input int y0, input int y1, input int y2, input int y3,
                              input int d, input int o);
    vec_t v;
    v.len   = len[8:0];
    v.shift = sh[5:0];
    v.n     = n[2:0];
    v.y[0]  = y0[19:0];
    v.y[1]  = y1[19:0];
    v.y[2]  = y2[19:0];
    v.y[3]  = y3[19:0];
    v.exp_d = d[7:0];
    v.exp_o = o[0];
    return v;
  endfunction

  function automatic logic [8:0] ref_result(input longint sum, input int sh);
    longint r;
    r = sum >>> sh;
    if (RELU && r < 0) r = 0;
    if (r > 127) return {1'b1, 8'd127};
    if (r < -128) return {1'b1, 8'h80};
    return {1'b0, r[7:0]};
  endfunction

  vec_t vecs[10];
  logic [8:0] exp_q[$];

  initial begin
    vecs[0] = mk(1, 0, 1, 5, 0, 0, 0, 5, 0);
    vecs[1] = mk(4, 2, 4, 100, 200, 300, 400, 127, 1);
    vecs[2] = mk(2, 0, 2, -3, -4, 0, 0, RELU ? 0 : -7, 0);
    vecs[3] = mk(1, 0, 1, -200, 0, 0, 0, RELU ? 0 : -128, RELU ? 0 : 1);
    vecs[4] = mk(3, 1, 3, -1, -1, -1, 0, RELU ? 0 : -2, 0);
    vecs[5] = mk(0, 0, 1, 7, 0, 0, 0, 7, 0);
    vecs[6] = mk(2, 63, 2, 1000, -2000, 0, 0, RELU ? 0 : -1, 0);
    vecs[7] = mk(3, 4, 3, -524288, -524288, -524288, 0, RELU ? 0 : -128, RELU ? 0 : 1);
    vecs[8] = mk(4, 0, 4, 127, 0, 0, 0, 127, 0);
    vecs[9] = mk(1, 0, 1, 128, 0, 0, 0, 127, 1);

    rst = 1'b1; cfg_len = 9'd1; cfg_shift = 6'd0; s_valid = 1'b0; s_y = '0; m_ready = 1'b1;
    tick();
    tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_ovf", m_ovf, 0);
    chk("rst_s_ready", s_ready, 1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      cfg_len = vecs[i].len;
      cfg_shift = vecs[i].shift;
      for (int k = 0; k < int'(vecs[i].n); k++) begin
        s_valid = 1'b1;
        s_y = vecs[i].y[k];
        tick();
        if (k == int'(vecs[i].n) - 2) chk($sformatf("vec%0d_early_valid", i), m_valid, 0);
      end
      s_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), m_valid, 1);
      chk($sformatf("vec%0d_data", i), m_data, vecs[i].exp_d);
      chk($sformatf("vec%0d_ovf", i), m_ovf, vecs[i].exp_o);
      tick();
      chk($sformatf("vec%0d_drain", i), m_valid, 0);
    end

    // Backpressure: result held, s_ready low, then combinational release.
    m_ready = 1'b0; cfg_len = 9'd1; cfg_shift = 6'd0;
    s_valid = 1'b1; s_y = 20'd42;
    tick();
    s_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_s_ready", s_ready, 0);
      chk("bp_m_data", m_data, 42);
      tick();
    end
    chk("bp_m_valid_held", m_valid, 1);
    m_ready = 1'b1;
    #1;
    chk("bp_s_ready_release", s_ready, 1);
    tick();
    chk("bp_drained", m_valid, 0);

    // Reset mid-product discards the partial sum.
    cfg_len = 9'd4;
    s_valid = 1'b1; s_y = 20'd9;
    tick(); tick();
    s_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    s_valid = 1'b1; s_y = 20'd1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k < 3) chk("rst_mid_no_valid", m_valid, 0);
    end
    s_valid = 1'b0;
    chk("rst_mid_valid", m_valid, 1);
    chk("rst_mid_data", m_data, 4);
    tick();

    // Back-to-back single-beat products.
    cfg_len = 9'd1;
    for (int k = 1; k <= 8; k++) begin
      s_valid = 1'b1; s_y = 20'(k);
      tick();
      chk("b2b_valid", m_valid, 1);
      chk("b2b_data", m_data, k);
    end
    s_valid = 1'b0;
    tick();
    chk("b2b_drain", m_valid, 0);

    // cfg_len changed mid-product only affects the next product.
    cfg_len = 9'd2;
    s_valid = 1'b1; s_y = 20'd10;
    tick();
    cfg_len = 9'd3; s_y = 20'd20;
    tick();
    chk("cfgchg_valid", m_valid, 1);
    chk("cfgchg_data", m_data, 30);
    s_y = 20'd1;
    tick(); tick();
    chk("cfgchg_next_pending", m_valid, 0);
    tick();
    s_valid = 1'b0;
    chk("cfgchg_next_data", m_data, 3);
    tick();

    // Over-range length clamps to N_MAX beats.
    cfg_len = 9'd511; cfg_shift = 6'd2;
    s_valid = 1'b1; s_y = 20'd1;
    for (int k = 0; k < 255; k++) tick();
    chk("clamp_early", m_valid, 0);
    tick();
    s_valid = 1'b0;
    chk("clamp_valid", m_valid, 1);
    chk("clamp_data", m_data, 64);
    chk("clamp_ovf", m_ovf, 0);
    tick();

    // Randomized traffic against a grouping scoreboard.
    begin
      int glen, gcnt, gshift, sv;
      longint gsum;
      logic [31:0] rv;
      logic exp_ready;
      glen = 1; gcnt = 0; gshift = 0; gsum = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        s_valid = ($urandom_range(0, 3) != 0);
        m_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 0) begin
          rv = $urandom();
          s_y = rv[19:0];
        end else begin
          sv = int'($urandom_range(0, 600)) - 300;
          s_y = sv[19:0];
        end
        if ($urandom_range(0, 7) == 0) begin
          cfg_len = 9'($urandom_range(0, 5));
          cfg_shift = 6'($urandom_range(0, 14));
        end
        #1;
        exp_ready = (exp_q.size() == 0) || m_ready;
        chk("rnd_s_ready", s_ready, exp_ready);
        if (exp_q.size() != 0 && m_ready) begin
          chk("rnd_m_data", m_data, exp_q[0][7:0]);
          chk("rnd_m_ovf", m_ovf, exp_q[0][8]);
          void'(exp_q.pop_front());
        end
        if (s_valid && exp_ready) begin
          if (gcnt == 0) begin
            glen = (cfg_len == 0) ? 1 : (cfg_len > 256 ? 256 : int'(cfg_len));
            gshift = int'(cfg_shift);
            gsum = 0;
          end
          gsum += longint'($signed(s_y));
          gcnt++;
          if (gcnt == glen) begin
            exp_q.push_back(ref_result(gsum, gshift));
            gcnt = 0;
          end
        end
        tick();
        chk("rnd_m_valid", m_valid, exp_q.size() != 0);
      end
    end

    s_valid = 1'b0; m_ready = 1'b1;
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
